// File: rtl/pipelined_datapath.sv
// Three-stage EX -> MEM -> WB datapath with register file, ALU, forwarding,
// load-use interlock and a valid/ready data-memory port. Define DP_FORWARD_EN
// to add the MEM->EX bypass; without it a RAW match against MEM stalls instead.
module pipelined_datapath #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [3:0]        alu_ctrl,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              zero_flag,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd_addr,
  output logic [XLEN-1:0]   wb_data
);
  localparam int NUM_REGS = 2**REG_AW;
  localparam int SHW      = $clog2(XLEN);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rs2;
  } ex_mem_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic [XLEN-1:0]   data;
  } mem_wb_t;

  // vld_pipe[0] = MEM stage occupied, vld_pipe[1] = WB stage occupied
  logic [1:0]                    vld_pipe_q, vld_pipe_d;
  ex_mem_t                       exm_q, exm_d;
  mem_wb_t                       mwb_q, mwb_d;
  logic                          zero_q, zero_d;
  logic [NUM_REGS-1:0][XLEN-1:0] rf_q, rf_d;

  logic            mem_op, mem_stall, mem_load, mem_prod;
  logic            mem_hit1, mem_hit2, raw_stall, accept;
  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [SHW-1:0]  shamt;

  assign mem_op    = vld_pipe_q[0] & (exm_q.mem_read | exm_q.mem_write);
  assign mem_stall = mem_op & ~dmem_ready;
  assign mem_load  = exm_q.mem_read & ~exm_q.mem_write & exm_q.mem_to_reg;
  assign mem_prod  = vld_pipe_q[0] & exm_q.reg_write & (exm_q.rd != '0);
  assign mem_hit1  = mem_prod & (exm_q.rd == rs1_addr);
  assign mem_hit2  = mem_prod & (exm_q.rd == rs2_addr);

`ifdef DP_FORWARD_EN
  assign raw_stall = (mem_hit1 | mem_hit2) & mem_load;
`else
  assign raw_stall = mem_hit1 | mem_hit2;
`endif

  assign in_ready = ~mem_stall & ~raw_stall;
  assign accept   = in_valid & in_ready;

  assign wb_valid   = vld_pipe_q[1] & mwb_q.reg_write & (mwb_q.rd != '0);
  assign wb_rd_addr = mwb_q.rd;
  assign wb_data    = mwb_q.data;

  assign dmem_req   = mem_op;
  assign dmem_we    = vld_pipe_q[0] & exm_q.mem_write;
  assign dmem_addr  = exm_q.alu;
  assign dmem_wdata = exm_q.rs2;
  assign zero_flag  = zero_q;

  // Operand select: later assignments win, giving MEM > WB > register file.
  always_comb begin
    op_a = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
    op_b = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
    if (wb_valid && mwb_q.rd == rs1_addr) op_a = mwb_q.data;
    if (wb_valid && mwb_q.rd == rs2_addr) op_b = mwb_q.data;
`ifdef DP_FORWARD_EN
    if (mem_hit1 && !mem_load) op_a = exm_q.alu;
    if (mem_hit2 && !mem_load) op_b = exm_q.alu;
`endif
  end

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b0111: alu_res[0] = $signed(op_a) < $signed(op_b);
      4'b1000: alu_res[0] = op_a < op_b;
      4'b1001: alu_res = op_a ^ op_b;
      4'b1010: alu_res = op_a << shamt;
      4'b1011: alu_res = op_a >> shamt;
      4'b1100: alu_res = $signed(op_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    exm_d      = exm_q;
    mwb_d      = mwb_q;
    zero_d     = zero_q;
    rf_d       = rf_q;

    // A waiting memory op freezes EX/MEM and zero_flag; otherwise EX/MEM
    // takes the accepted instruction or a bubble.
    if (!mem_stall) begin
      vld_pipe_d[0] = accept;
      if (accept) begin
        exm_d.rd         = rd_addr;
        exm_d.reg_write  = reg_write;
        exm_d.mem_read   = mem_read;
        exm_d.mem_write  = mem_write;
        exm_d.mem_to_reg = mem_to_reg;
        exm_d.alu        = alu_res;
        exm_d.rs2        = op_b;
        zero_d           = (alu_res == '0);
      end
    end

    vld_pipe_d[1] = vld_pipe_q[0] & ~mem_stall;
    if (vld_pipe_q[0] && !mem_stall) begin
      mwb_d.rd        = exm_q.rd;
      mwb_d.reg_write = exm_q.reg_write;
      mwb_d.data      = mem_load ? dmem_rdata : exm_q.alu;
    end

    if (wb_valid) rf_d[mwb_q.rd] = mwb_q.data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      exm_q      <= '0;
      mwb_q      <= '0;
      zero_q     <= 1'b0;
      rf_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      exm_q      <= exm_d;
      mwb_q      <= mwb_d;
      zero_q     <= zero_d;
      rf_q       <= rf_d;
    end
  end

endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
- Parametrised three-stage datapath (EX -> MEM -> WB) with an internal register file and ALU.
- External data memory is reached through a valid/ready handshake, so memory wait states stall the pipeline.
- Operand forwarding and hazard interlock are built in; instructions arrive pre-decoded from the control unit through an in_valid/in_ready handshake.

Parameters:
- XLEN, 32, datapath and register width; 8..64.
- REG_AW, 5, register address width; NUM_REGS = 2**REG_AW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  EX stage accepts the instruction this cycle.
- rs1_addr  in  REG_AW  source register 1.
- rs2_addr  in  REG_AW  source register 2.
- rd_addr  in  REG_AW  destination register.
- alu_ctrl  in  4  ALU operation.
- reg_write  in  1  write rd at WB.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_to_reg  in  1  write back memory data.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  ALU result.
- dmem_wdata  out  XLEN  rs2 value.
- dmem_ready  in  1  memory completes the request this cycle.
- dmem_rdata  in  XLEN  load data, valid when dmem_req & dmem_ready.
- zero_flag  out  1  ALU result == 0 for the instruction in MEM.
- wb_valid  out  1  register write performed this cycle.
- wb_rd_addr  out  REG_AW  register written.
- wb_data  out  XLEN  value written.

Behaviour:
- Reset: asynchronous assertion clears all stage valid bits, the whole register file, zero_flag, dmem_req, dmem_we and wb_valid immediately. In-flight instructions are discarded, including a request pending on dmem_req. in_ready = 1 after release.
- Accept: an instruction is accepted on in_valid & in_ready.

EX stage:
- Reads operands, with forwarding applied, and computes the ALU result.
- Captures into the EX/MEM register on accept. Otherwise EX/MEM is loaded with a bubble, unless MEM is stalled, in which case it holds.

ALU encoding (unlisted codes give 0):
- 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed); 1000 SLTU; 1001 XOR.
- 1010 SLL, 1011 SRL, 1100 SRA: shift amount is op_b[$clog2(XLEN)-1:0].
- Arithmetic wraps modulo 2**XLEN.

Register file:
- x0 always reads 0; writes to x0 are dropped and wb_valid stays 0.
- A write in WB and a read in EX to the same register in the same cycle return the new value (internal write-through).

MEM stage:
- Memory op = mem_read | mem_write; mem_write takes precedence when both are set.
- For a memory op, dmem_req = 1 with addr/we/wdata held stable until the cycle dmem_ready = 1. Zero-wait completion, with ready high in the first request cycle, is legal.
- While waiting, MEM stalls: EX holds, in_ready = 0, and a bubble advances into WB.
- zero_flag is registered from the EX/MEM result and holds during a stall.

WB stage:
- Write data = dmem_rdata captured at completion if mem_read & mem_to_reg & !mem_write; else the ALU result.
- wb_valid = valid & reg_write & rd != 0.

Hazards:
- Only a producer with reg_write = 1 and rd != 0 counts.
- Load-use: a load in MEM whose rd matches rs1 or rs2 forces in_ready = 0 until the load reaches WB.
- Priority of operand sources: MEM-stage ALU result (non-load), then WB value, then register file.

Latency: result is written to the register file 3 cycles after accept with no wait states.

Optional Feature:
- Macro: DP_FORWARD_EN.
- Defined: MEM-to-EX forwarding as above.
- Undefined: no MEM-to-EX path. Any RAW match against the MEM stage deasserts in_ready for one extra cycle. WB write-through is always present.
- Register results are identical in both builds; only cycle counts differ.

Test Plan:
- Reset mid-request: assert rst while dmem_req = 1 and dmem_ready = 0 -> dmem_req = 0 within the same cycle; all registers read 0; in_ready = 1 after release.
- Load, zero wait: load x1 from addr 0 (ADD x0,x0) with dmem_rdata = 0x0000_0005 and ready tied high -> wb_valid with rd = 1 and data 5, exactly 3 cycles after accept.
- Wait states: same load with dmem_ready delayed 4 cycles -> dmem_addr/we stable throughout, in_ready = 0 for 4 cycles, writeback 4 cycles later.
- Load-use: load x1 = 7, then ADD x2 = x1 + x1 -> one-cycle in_ready = 0 bubble, x2 = 14.
- ALU back-to-back: x1 = 5, x2 = 3 (via loads), then back-to-back SUB x3 = x2 - x1, SRA x4 = x3 >> x2 -> x3 = 0xFFFF_FFFE, x4 = 0xFFFF_FFFF. With DP_FORWARD_EN, zero bubbles; without it, one bubble.
- x0 and precedence: write to x0 -> wb_valid = 0 and reads stay 0. mem_read & mem_write both set -> dmem_we = 1 and rd gets the ALU result.
